// File: rtl/uart_frame_sequencer_if.sv
// Signal bundle between the frame sequencer and its UART / memory / downsampler neighbours.
interface uart_frame_sequencer_if #(
    parameter int ADDR_W = 20
);
    logic              recieve_start;
    logic              recieving;
    logic              recieve_over;
    logic              transmit_active;
    logic              transmit_over;
    logic              finish;
    logic [ADDR_W-1:0] address_uart;
    logic              mem_en;
    logic              mem_we;
    logic              transmit_begin;
    logic              start_calculation;
    logic [1:0]        phase;
    logic              done;

    modport master (
        input  recieve_start, recieving, recieve_over, transmit_active, transmit_over, finish,
        output address_uart, mem_en, mem_we, transmit_begin, start_calculation, phase, done
    );

    modport slave (
        output recieve_start, recieving, recieve_over, transmit_active, transmit_over, finish,
        input  address_uart, mem_en, mem_we, transmit_begin, start_calculation, phase, done
    );
endinterface

// File: rtl/uart_frame_sequencer.sv
// Receive a frame into memory, run the downsampler, transmit the result frame.
// UART_SEQ_LOOP_EN: when defined, DONE pulses for one cycle and the next frame starts.
module uart_frame_sequencer #(
    parameter int ADDR_W   = 20,
    parameter int RX_BASE  = 0,
    parameter int RX_COUNT = 65536,
    parameter int TX_BASE  = 65536,
    parameter int TX_COUNT = 16384
) (
    input  logic                   s_tick,
    input  logic                   rst,
    uart_frame_sequencer_if.master bus
);
    localparam longint unsigned RX_END    = longint'(RX_BASE) + longint'(RX_COUNT) - 64'd1;
    localparam longint unsigned TX_END    = longint'(TX_BASE) + longint'(TX_COUNT) - 64'd1;
    localparam longint unsigned ADDR_SPAN = 64'd1 << ADDR_W;

    localparam logic [ADDR_W-1:0] RX_FIRST = ADDR_W'(RX_BASE);
    localparam logic [ADDR_W-1:0] RX_LAST  = ADDR_W'(RX_END);
    localparam logic [ADDR_W-1:0] TX_FIRST = ADDR_W'(TX_BASE);
    localparam logic [ADDR_W-1:0] TX_LAST  = ADDR_W'(TX_END);

    // The address counter never wraps, so both phase ranges must fit the address width.
    generate
        if (RX_COUNT < 1 || TX_COUNT < 1 || RX_END >= ADDR_SPAN || TX_END >= ADDR_SPAN) begin : g_bad_cfg
            $error("uart_frame_sequencer: RX/TX address range does not fit ADDR_W");
        end
    endgenerate

    typedef enum logic [3:0] {
        RX_IDLE, RX_DATA, WR, WR_HOLD, RX_NEXT, CALC,
        TX_RD, TX_HOLD, TX_START, TX_WAIT, TX_NEXT, DONE
    } state_t;

    state_t state;

    // Outputs are registered alongside the state, so each is set on entry to the state that owns it.
    always_ff @(posedge s_tick) begin
        if (rst) begin
            state                 <= RX_IDLE;
            bus.address_uart      <= RX_FIRST;
            bus.mem_en            <= 1'b0;
            bus.mem_we            <= 1'b0;
            bus.transmit_begin    <= 1'b0;
            bus.start_calculation <= 1'b0;
            bus.done              <= 1'b0;
            bus.phase             <= 2'd0;
        end else begin
            case (state)
                RX_IDLE: if (bus.recieve_start) state <= RX_DATA;
                RX_DATA: begin
                    if (!bus.recieving) begin
                        state      <= WR;
                        bus.mem_en <= 1'b1;
                        bus.mem_we <= 1'b1;
                    end
                end
                WR: state <= WR_HOLD;
                WR_HOLD: begin
                    state      <= RX_NEXT;
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                end
                RX_NEXT: begin
                    if (bus.recieve_over) begin
                        if (bus.address_uart == RX_LAST) begin
                            state                 <= CALC;
                            bus.start_calculation <= 1'b1;
                            bus.phase             <= 2'd1;
                        end else begin
                            state            <= RX_IDLE;
                            bus.address_uart <= bus.address_uart + ADDR_W'(1);
                        end
                    end
                end
                CALC: begin
                    if (bus.finish) begin
                        state                 <= TX_RD;
                        bus.start_calculation <= 1'b0;
                        bus.address_uart      <= TX_FIRST;
                        bus.mem_en            <= 1'b1;
                        bus.mem_we            <= 1'b0;
                        bus.phase             <= 2'd2;
                    end
                end
                TX_RD: state <= TX_HOLD;
                TX_HOLD: begin
                    state              <= TX_START;
                    bus.transmit_begin <= 1'b1;
                end
                // Read data stays presented until the transmitter has taken the byte.
                TX_START: begin
                    if (bus.transmit_active) begin
                        state              <= TX_WAIT;
                        bus.transmit_begin <= 1'b0;
                        bus.mem_en         <= 1'b0;
                    end
                end
                TX_WAIT: if (!bus.transmit_active) state <= TX_NEXT;
                TX_NEXT: begin
                    if (bus.transmit_over) begin
                        if (bus.address_uart == TX_LAST) begin
                            state     <= DONE;
                            bus.done  <= 1'b1;
                            bus.phase <= 2'd3;
                        end else begin
                            state            <= TX_RD;
                            bus.address_uart <= bus.address_uart + ADDR_W'(1);
                            bus.mem_en       <= 1'b1;
                        end
                    end
                end
                DONE: begin
`ifdef UART_SEQ_LOOP_EN
                    state            <= RX_IDLE;
                    bus.done         <= 1'b0;
                    bus.phase        <= 2'd0;
                    bus.address_uart <= RX_FIRST;
`else
                    state    <= DONE;
                    bus.done <= 1'b1;
`endif
                end
                default: begin
                    state                 <= RX_IDLE;
                    bus.address_uart      <= RX_FIRST;
                    bus.mem_en            <= 1'b0;
                    bus.mem_we            <= 1'b0;
                    bus.transmit_begin    <= 1'b0;
                    bus.start_calculation <= 1'b0;
                    bus.done              <= 1'b0;
                    bus.phase             <= 2'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Randomized frame traffic with a queue scoreboard; the monitor checks every memory access,
// transmit handshake, calculation start and done indication against bench expectations.
module tb_uart_frame_sequencer;
    localparam int ADDR_W   = 8;
    localparam int RX_BASE  = 0;
    localparam int RX_COUNT = 4;
    localparam int TX_BASE  = 16;
    localparam int TX_COUNT = 2;

    logic s_tick = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   hold_finish = 1'b0;

    uart_frame_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    uart_frame_sequencer #(
        .ADDR_W(ADDR_W), .RX_BASE(RX_BASE), .RX_COUNT(RX_COUNT),
        .TX_BASE(TX_BASE), .TX_COUNT(TX_COUNT)
    ) dut (
        .s_tick(s_tick),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 s_tick = ~s_tick;

    int exp_wr[$];
    int exp_rd[$];
    int exp_tb[$];

    task automatic check(string name, longint act, longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic abort(string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic pop_check(string name, inout int q[$], input longint act);
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got %0d, want nothing", name, act);
        end else begin
            check(name, act, q.pop_front());
        end
    endtask

    // ---------------- monitor ----------------
    int   wr_run = 0, tb_run = 0, sc_run = 0, done_run = 0;
    int   frame_wr = 0, frame_rd = 0, wr_exp_addr = 0;
    logic prev_rd = 1'b0;

    always @(posedge s_tick) begin
        #1;
        if (rst) begin
            check("rst_addr", bus.address_uart, RX_BASE);
            check("rst_mem_en", bus.mem_en, 0);
            check("rst_mem_we", bus.mem_we, 0);
            check("rst_tx_begin", bus.transmit_begin, 0);
            check("rst_start_calc", bus.start_calculation, 0);
            check("rst_done", bus.done, 0);
            check("rst_phase", bus.phase, 0);
            wr_run = 0; tb_run = 0; sc_run = 0; done_run = 0;
            frame_wr = 0; frame_rd = 0; prev_rd = 1'b0;
        end else begin
            if (bus.mem_en && bus.mem_we) begin
                if (wr_run == 0) begin
                    wr_exp_addr = (exp_wr.size() != 0) ? exp_wr[0] : -1;
                    pop_check("wr_addr", exp_wr, bus.address_uart);
                    check("wr_phase", bus.phase, 0);
                    frame_wr++;
                end else begin
                    check("wr_addr_hold", bus.address_uart, wr_exp_addr);
                end
                wr_run++;
            end else if (wr_run != 0) begin
                check("wr_pulse_len", wr_run, 2);
                wr_run = 0;
            end

            if (bus.mem_en && !bus.mem_we && !prev_rd) begin
                pop_check("rd_addr", exp_rd, bus.address_uart);
                check("rd_phase", bus.phase, 2);
                frame_rd++;
            end
            prev_rd = bus.mem_en && !bus.mem_we;

            if (bus.transmit_begin) tb_run++;
            else if (tb_run != 0) begin
                pop_check("tx_begin_len", exp_tb, tb_run);
                tb_run = 0;
            end

            if (bus.start_calculation) begin
                if (sc_run == 0) begin
                    check("calc_after_writes", frame_wr, RX_COUNT);
                    check("calc_phase", bus.phase, 1);
                    frame_wr = 0;
                end
                sc_run++;
            end else if (sc_run != 0) begin
                if (hold_finish) check("calc_first_cycle_accept", sc_run, 1);
                sc_run = 0;
            end

            if (bus.done) begin
                if (done_run == 0) begin
                    check("done_after_reads", frame_rd, TX_COUNT);
                    check("done_phase", bus.phase, 3);
                    frame_rd = 0;
                end
                done_run++;
            end else if (done_run != 0) begin
`ifdef UART_SEQ_LOOP_EN
                check("done_pulse_len", done_run, 1);
`else
                check("done_held", bus.done, 1);
`endif
                done_run = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick(int n = 1);
        repeat (n) @(negedge s_tick);
    endtask

    // Returns with aborted=1 when reset was fired during the write of this byte.
    task automatic rx_byte(int idx, bit poke_start, bit rst_mid, output bit aborted);
        aborted = 1'b0;
        exp_wr.push_back(RX_BASE + idx);
        tick($urandom_range(0, 3));
        bus.recieve_start = 1'b1;
        bus.recieving     = 1'b1;
        tick();
        bus.recieve_start = 1'b0;
        tick($urandom_range(1, 4));
        bus.recieving = 1'b0;
        tick();
        if (rst_mid) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            aborted = 1'b1;
            return;
        end
        tick(2);
        if (poke_start) begin
            bus.recieve_start = 1'b1;
            tick();
            bus.recieve_start = 1'b0;
        end else begin
            tick($urandom_range(0, 2));
        end
        bus.recieve_over = 1'b1;
        tick();
        bus.recieve_over = 1'b0;
    endtask

    task automatic tx_byte(int idx, int dly);
        int n = 0;
        while (!bus.transmit_begin) begin
            tick();
            if (++n > 60) abort("wait_tx_begin");
        end
        exp_tb.push_back(dly);
        tick(dly - 1);
        bus.transmit_active = 1'b1;
        tick($urandom_range(1, 3));
        bus.transmit_active = 1'b0;
        tick();
        if (idx < TX_COUNT - 1) exp_rd.push_back(TX_BASE + idx + 1);
        tick($urandom_range(0, 2));
        bus.transmit_over = 1'b1;
        tick();
        bus.transmit_over = 1'b0;
    endtask

    task automatic frame(int rst_at, int first_dly, output bit aborted);
        int n = 0;
        for (int i = 0; i < RX_COUNT; i++) begin
            if (i == RX_COUNT - 1) exp_rd.push_back(TX_BASE);
            rx_byte(i, 1'($urandom_range(0, 1)), i == rst_at, aborted);
            if (aborted) return;
        end
        if (!hold_finish) begin
            tick($urandom_range(0, 3));
            bus.finish = 1'b1;
            tick();
            bus.finish = 1'b0;
        end
        for (int j = 0; j < TX_COUNT; j++)
            tx_byte(j, (j == 0) ? first_dly : int'($urandom_range(1, 6)));
        while (!bus.done) begin
            tick();
            if (++n > 30) abort("wait_done");
        end
        // A start bit seen in DONE must not begin a new byte.
        bus.recieve_start = 1'b1;
        tick();
        bus.recieve_start = 1'b0;
        tick(3);
`ifndef UART_SEQ_LOOP_EN
        check("done_terminal", bus.done, 1);
        check("done_terminal_phase", bus.phase, 3);
        check("done_no_mem", bus.mem_en, 0);
`else
        check("loop_back_phase", bus.phase, 0);
        check("loop_back_addr", bus.address_uart, RX_BASE);
`endif
    endtask

    initial begin
        bit ab;
        rst = 1'b1;
        bus.recieve_start = 1'b0; bus.recieving = 1'b0; bus.recieve_over = 1'b0;
        bus.transmit_active = 1'b0; bus.transmit_over = 1'b0;
        // finish held from reset: ignored during receive, taken in the first CALC cycle
        hold_finish = 1'b1;
        bus.finish  = 1'b1;
        tick(3);
        rst = 1'b0;
        frame(-1, 5, ab);
        hold_finish = 1'b0;
        bus.finish  = 1'b0;
`ifndef UART_SEQ_LOOP_EN
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
`endif
        frame(2, 3, ab);
        check("rst_mid_write_seen", ab, 1);
        exp_wr.delete();
        exp_rd.delete();
        exp_tb.delete();
        tick(2);
        frame(-1, $urandom_range(1, 6), ab);
        tick(2);
        check("wr_queue_drained", exp_wr.size(), 0);
        check("rd_queue_drained", exp_rd.size(), 0);
        check("tb_queue_drained", exp_tb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        abort("global_watchdog");
    end
endmodule

// File: doc/uart_frame_sequencer.md
UART_FRAME_SEQUENCER -- requirements
Module: uart_frame_sequencer

Interface
REQ-001 Parameter: ADDR_W, 20, memory address width in bits.
REQ-002 Parameter: RX_BASE, 0, first address written in the receive phase.
REQ-003 Parameter: RX_COUNT, 65536, number of words received (>=1).
REQ-004 Parameter: TX_BASE, 65536, first address read in the transmit phase.
REQ-005 Parameter: TX_COUNT, 16384, number of words transmitted (>=1).
REQ-006 s_tick  in  1  sole clock, rising edge; one clock; reset is synchronous and active-high.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 recieve_start  in  1  UART RX start bit detected.
REQ-009 recieving  in  1  UART RX shifting data bits.
REQ-010 recieve_over  in  1  UART RX stop bit complete.
REQ-011 transmit_active  in  1  UART TX busy.
REQ-012 transmit_over  in  1  UART TX stop bit complete.
REQ-013 finish  in  1  downsampling engine complete.
REQ-014 address_uart  out  ADDR_W  memory address.
REQ-015 mem_en  out  1  memory port enable.
REQ-016 mem_we  out  1  write enable, 1=write, 0=read; meaningful only with mem_en=1.
REQ-017 transmit_begin  out  1  request a UART TX byte.
REQ-018 start_calculation  out  1  downsampling engine start level.
REQ-019 phase  out  2  0=receive, 1=calculate, 2=transmit, 3=done.
REQ-020 done  out  1  frame transmitted.

Function
REQ-021 States SHALL be: RX_IDLE, RX_DATA, WR, WR_HOLD, RX_NEXT, CALC, TX_RD, TX_HOLD, TX_START, TX_WAIT, TX_NEXT, DONE; all registered on s_tick.
REQ-022 RX_IDLE: recieve_start=1 -> RX_DATA; otherwise stay.
REQ-023 RX_DATA: recieving=0 -> WR.
REQ-024 WR and WR_HOLD: mem_en=1, mem_we=1; one cycle each, so every write is a 2-cycle pulse at a stable address_uart; WR -> WR_HOLD -> RX_NEXT.
REQ-025 RX_NEXT: mem_en=0, mem_we=0; wait for recieve_over=1; then at address RX_BASE+RX_COUNT-1 -> CALC (address unchanged), else address_uart+1 -> RX_IDLE.
REQ-026 CALC: start_calculation=1 held; finish=1 (including in the first CALC cycle) -> start_calculation=0, address_uart=TX_BASE -> TX_RD.
REQ-027 TX_RD and TX_HOLD: mem_en=1, mem_we=0, one cycle each; TX_RD -> TX_HOLD -> TX_START.
REQ-028 TX_START: transmit_begin=1 and mem_en held at 1 until transmit_active=1, then transmit_begin=0 -> TX_WAIT.
REQ-029 TX_WAIT: transmit_active=0 -> TX_NEXT.
REQ-030 TX_NEXT: mem_en=0; wait for transmit_over=1; then at TX_BASE+TX_COUNT-1 -> DONE, else address_uart+1 -> TX_RD.
REQ-031 DONE: done=1, phase=3, mem_en=0.
REQ-032 Inputs SHALL be ignored outside the state that samples them (e.g. recieve_start during CALC, finish during RX).
REQ-033 address_uart SHALL never wrap: elaboration fails unless RX_BASE+RX_COUNT-1 and TX_BASE+TX_COUNT-1 are each < 2^ADDR_W.
REQ-034 COUNT=1: the first word is the last word; no increment occurs in that phase.
REQ-035 Unreachable state encodings SHALL go to RX_IDLE on the next clock.

Reset
REQ-036 rst=1 SHALL override all other inputs: state=RX_IDLE, address_uart=RX_BASE, mem_en=0, mem_we=0, transmit_begin=0, start_calculation=0, done=0, phase=0.
REQ-037 rst=1 mid-write or mid-transmit SHALL drop every output to its reset value on the next edge, with no trailing write.

Configuration
REQ-038 Macro UART_SEQ_LOOP_EN defined: DONE lasts 1 cycle (done pulses once), then address_uart=RX_BASE -> RX_IDLE for the next frame.
REQ-039 UART_SEQ_LOOP_EN undefined: DONE is terminal until rst, with done held at 1.

Verification (RX_BASE=0, RX_COUNT=4, TX_BASE=16, TX_COUNT=2, ADDR_W=8)
REQ-040 Feed 4 RX bytes -> 4 two-cycle mem_we pulses at addresses 0,1,2,3; start_calculation rises after the 4th recieve_over.
REQ-041 Hold finish=1 from reset -> ignored during RX; accepted in the first CALC cycle; first TX read at address 16.
REQ-042 Delay transmit_active 5 cycles after transmit_begin -> transmit_begin stays high 5 cycles; reads occur at 16 then 17, then done=1.
REQ-043 Assert rst during the 3rd RX write -> next cycle mem_en=0, address_uart=0, state RX_IDLE; full frame then completes correctly.
REQ-044 With UART_SEQ_LOOP_EN defined, run two frames -> done pulses for exactly 1 cycle per frame; second frame writes start at 0. Without the macro, done stays 1 after frame 1.
REQ-045 Pulse recieve_start during RX_NEXT and in DONE -> no state change and no extra write.
